// File: rtl/ospi_ctrl_pkg.sv
// Shared definitions for the OSPI flash controller: host op encodings,
// the controller FSM state type and the value an erased flash byte reads as.
package ospi_ctrl_pkg;

   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_ERASE   = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   localparam logic [7:0] ERASED_VAL = 8'hFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EXEC  = 3'd2,
      CAPT  = 3'd3,
      BUSY  = 3'd4,
      VRD   = 3'd5,
      VCMP  = 3'd6,
      RESP  = 3'd7
   } ospi_state_t;

endpackage

// File: rtl/ospi_busy_timer.sv
// Erase busy-wait timer. load arms the counter with CYCLES; count steps it
// down once per cycle; done is high during the last cycle of the wait.
module ospi_busy_timer #(
   parameter int unsigned CYCLES = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic count,
   output logic done
);

   localparam int unsigned CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt;

   // Down-counter: load wins over count, and it parks at zero once expired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(CYCLES);
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign done = (cnt == CW'(1));

endmodule

// File: rtl/ospi_flash_ctrl.sv
// OSPI flash controller: accepts one host request at a time (read, write,
// erase), sequences the flash strobes and returns a single-cycle response.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle; rsp_valid is a
// one-cycle pulse with no backpressure.
// Optional feature: define OSPI_CTRL_WRITE_VERIFY_EN to read back every
// write and flag a mismatch in rsp_err.
module ospi_flash_ctrl
   import ospi_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_LIMIT   = 256,
   parameter int unsigned ERASE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [23:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   input  logic        hold_req,
   output logic        flash_cs_n,
   output logic        flash_we,
   output logic        flash_re,
   output logic        flash_ee,
   output logic [23:0] flash_addr,
   output logic [7:0]  flash_din,
   input  logic [7:0]  flash_dout,
   output logic        flash_hold_n,
   output ospi_state_t state
);

   localparam logic [24:0] LIMIT = 25'(ADDR_LIMIT);

   logic [1:0] op_q;
   logic       hold_q;
   logic       req_bad;
   logic       erase_done;

   assign req_bad = (req_op == OP_ILLEGAL) || ({1'b0, req_addr} >= LIMIT);

   ospi_busy_timer #(.CYCLES(ERASE_CYCLES)) u_busy_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    ((state == EXEC) && (op_q == OP_ERASE)),
      .count   (state == BUSY),
      .done    (erase_done)
   );

   // Controller FSM with registered outputs. flash_addr/flash_din double as
   // the address and write-data latches for the whole flash access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= ERASED_VAL;
         flash_cs_n   <= 1'b1;
         flash_we     <= 1'b0;
         flash_re     <= 1'b0;
         flash_ee     <= 1'b0;
         flash_addr   <= '0;
         flash_din    <= '0;
         flash_hold_n <= 1'b1;
         hold_q       <= 1'b0;
         op_q         <= OP_READ;
      end else begin
         hold_q       <= hold_req;
         flash_hold_n <= !hold_req;
         rsp_valid    <= 1'b0;
         flash_we     <= 1'b0;
         flash_re     <= 1'b0;
         flash_ee     <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  op_q      <= req_op;
                  if (req_bad) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= ERASED_VAL;
                  end else begin
                     state      <= SETUP;
                     flash_cs_n <= 1'b0;
                     flash_addr <= req_addr;
                     flash_din  <= req_wdata;
                  end
               end
            end
            SETUP: begin
               // The flash hold input lags by a cycle, so wait for two quiet cycles.
               if (!hold_req && !hold_q) begin
                  state <= EXEC;
                  case (op_q)
                     OP_READ:  flash_re <= 1'b1;
                     OP_WRITE: flash_we <= 1'b1;
                     OP_ERASE: flash_ee <= 1'b1;
                     default:  ;
                  endcase
               end
            end
            EXEC: begin
               case (op_q)
                  OP_READ:  state <= CAPT;
                  OP_ERASE: state <= BUSY;
`ifdef OSPI_CTRL_WRITE_VERIFY_EN
                  OP_WRITE: begin
                     state    <= VRD;
                     flash_re <= 1'b1;
                  end
`else
                  OP_WRITE: begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= ERASED_VAL;
                  end
`endif
                  default: begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= ERASED_VAL;
                  end
               endcase
            end
            CAPT: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= flash_dout;
            end
            BUSY: begin
               if (erase_done) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= ERASED_VAL;
               end
            end
`ifdef OSPI_CTRL_WRITE_VERIFY_EN
            VRD: begin
               state <= VCMP;
            end
            VCMP: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= (flash_dout != flash_din);
               rsp_rdata <= flash_dout;
            end
`endif
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               flash_cs_n <= 1'b1;
               flash_addr <= '0;
               flash_din  <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Self-checking bench for ospi_flash_ctrl: a flash memory model drives
// flash_dout, a cycle-level reference model predicts every DUT output,
// and directed cases pin known latencies and data values.
// Build with OSPI_CTRL_WRITE_VERIFY_EN defined to cover the verify feature.
module tb_ospi_flash_ctrl;
   import ospi_ctrl_pkg::*;

   localparam int ADDR_LIMIT   = 256;
   localparam int ERASE_CYCLES = 8;
`ifdef OSPI_CTRL_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [23:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        hold_req;
   logic        flash_cs_n;
   logic        flash_we;
   logic        flash_re;
   logic        flash_ee;
   logic [23:0] flash_addr;
   logic [7:0]  flash_din;
   logic [7:0]  flash_dout;
   logic        flash_hold_n;
   ospi_state_t state;

   logic [7:0] flash_mem [256];
   logic [7:0] ref_mem [256];
   logic       corrupt_en;

   int tests_run;
   int tests_failed;
   int cyc;

   // reference model of the single outstanding transaction
   bit          m_active;
   bit          m_legal;
   bit          m_in_setup;
   int          m_accept;
   int          m_exec;
   int          m_resp;
   logic [1:0]  m_op;
   logic [23:0] m_addr;
   logic [7:0]  m_wdata;
   int          since_rst;
   bit          prev_hold;
   logic [8:0]  exp_q[$];
   bit          chk_q[$];

   ospi_flash_ctrl #(.ADDR_LIMIT(ADDR_LIMIT), .ERASE_CYCLES(ERASE_CYCLES)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .hold_req     (hold_req),
      .flash_cs_n   (flash_cs_n),
      .flash_we     (flash_we),
      .flash_re     (flash_re),
      .flash_ee     (flash_ee),
      .flash_addr   (flash_addr),
      .flash_din    (flash_din),
      .flash_dout   (flash_dout),
      .flash_hold_n (flash_hold_n),
      .state        (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // flash device model
   assign flash_dout = (corrupt_en && state == VCMP) ? 8'h00 : flash_mem[flash_addr[7:0]];

   always @(posedge clk) begin
      if (!flash_cs_n) begin
         if (flash_we) flash_mem[flash_addr[7:0]] = flash_din;
         if (flash_ee) flash_mem[flash_addr[7:0]] = 8'hFF;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // per-cycle compare against the reference model
   initial begin
      bit rdy_exp, rv_exp, re_exp, we_exp, ee_exp, cs_exp, hn_exp;
      logic [8:0] e;
      bit ck;
      cyc = 0;
      m_active = 0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!reset_n) begin
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("rst_rsp_err", 32'(rsp_err), 32'(0));
            check("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
            check("rst_cs_n", 32'(flash_cs_n), 32'(1));
            check("rst_strobes", 32'({flash_re, flash_we, flash_ee}), 32'(0));
            check("rst_addr_din", 32'({flash_addr, flash_din}), 32'(0));
            check("rst_hold_n", 32'(flash_hold_n), 32'(1));
            check("rst_state", 32'(state), 32'(IDLE));
            m_active  = 0;
            exp_q.delete();
            chk_q.delete();
            since_rst = 0;
            prev_hold = 0;
         end else begin
            rdy_exp = !m_active && (since_rst >= 1);
            rv_exp  = m_active && (cyc == m_resp);
            cs_exp  = !(m_active && m_legal);
            re_exp  = m_active && m_legal &&
                      (((m_op == OP_READ) && (cyc == m_exec)) ||
                       (VERIFY && (m_op == OP_WRITE) && (cyc == m_exec + 1)));
            we_exp  = m_active && m_legal && (m_op == OP_WRITE) && (cyc == m_exec);
            ee_exp  = m_active && m_legal && (m_op == OP_ERASE) && (cyc == m_exec);
            hn_exp  = (since_rst == 0) ? 1'b1 : !prev_hold;
            check("req_ready", 32'(req_ready), 32'(rdy_exp));
            check("rsp_valid", 32'(rsp_valid), 32'(rv_exp));
            check("flash_cs_n", 32'(flash_cs_n), 32'(cs_exp));
            check("flash_re", 32'(flash_re), 32'(re_exp));
            check("flash_we", 32'(flash_we), 32'(we_exp));
            check("flash_ee", 32'(flash_ee), 32'(ee_exp));
            check("flash_hold_n", 32'(flash_hold_n), 32'(hn_exp));
            if (m_active && m_legal) begin
               check("flash_addr", 32'(flash_addr), 32'(m_addr));
               check("flash_din", 32'(flash_din), 32'(m_wdata));
            end
            if (!m_active && since_rst >= 1) check("state_idle", 32'(state), 32'(IDLE));
            if (rv_exp) begin
               if (exp_q.size() > 0) begin
                  e  = exp_q.pop_front();
                  ck = chk_q.pop_front();
                  check("rsp_err", 32'(rsp_err), 32'(e[8]));
                  if (ck) check("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
               end
               m_active = 0;
            end
            if (rdy_exp && req_valid) begin
               m_active = 1;
               m_accept = cyc;
               m_op     = req_op;
               m_addr   = req_addr;
               m_wdata  = req_wdata;
               m_exec   = -10;
               m_resp   = -10;
               m_legal  = (req_op != OP_ILLEGAL) && (int'(req_addr) < ADDR_LIMIT);
               if (!m_legal) begin
                  m_in_setup = 0;
                  m_resp     = cyc + 1;
                  exp_q.push_back({1'b1, 8'hFF});
                  chk_q.push_back(1'b1);
               end else begin
                  m_in_setup = 1;
                  case (req_op)
                     OP_READ: begin
                        exp_q.push_back({1'b0, ref_mem[req_addr[7:0]]});
                        chk_q.push_back(1'b1);
                     end
                     OP_WRITE: begin
                        if (VERIFY) begin
                           exp_q.push_back(corrupt_en ? {1'b1, 8'h00} : {1'b0, req_wdata});
                           chk_q.push_back(1'b1);
                        end else begin
                           exp_q.push_back({1'b0, 8'hFF});
                           chk_q.push_back(1'b0);
                        end
                        ref_mem[req_addr[7:0]] = req_wdata;
                     end
                     default: begin
                        exp_q.push_back({1'b0, 8'hFF});
                        chk_q.push_back(1'b0);
                        ref_mem[req_addr[7:0]] = 8'hFF;
                     end
                  endcase
               end
            end
            if (m_active && m_in_setup && (cyc > m_accept) && !hold_req && !prev_hold) begin
               m_in_setup = 0;
               m_exec     = cyc + 1;
               case (m_op)
                  OP_READ:  m_resp = m_exec + 2;
                  OP_WRITE: m_resp = m_exec + (VERIFY ? 3 : 1);
                  default:  m_resp = m_exec + 1 + ERASE_CYCLES;
               endcase
            end
            prev_hold = hold_req;
            since_rst++;
         end
      end
   end

   // driver: issue one request, optional hold window, optional reset at cycle rst_at
   task automatic do_req(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                         input int hold_from, input int hold_len, input bit corrupt,
                         input int rst_at, output int lat, output logic err,
                         output logic [7:0] rdata);
      int n;
      lat   = -1;
      err   = 1'b0;
      rdata = 8'h00;
      @(negedge clk);
      req_valid  = 1'b1;
      req_op     = op;
      req_addr   = addr;
      req_wdata  = wd;
      hold_req   = 1'b0;
      corrupt_en = corrupt;
      #1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("req_accepted", 32'(req_ready), 32'(1));
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         hold_req  = (k >= hold_from) && (k < hold_from + hold_len);
         if (k == rst_at) begin
            reset_n = 1'b0;
            return;
         end
         #1;
         if (rsp_valid) begin
            lat   = k;
            err   = rsp_err;
            rdata = rsp_rdata;
            break;
         end
      end
      check("rsp_seen", 32'(lat > 0), 32'(1));
   endtask

   // main sequence
   initial begin
      int lat;
      logic err;
      logic [7:0] rd;
      int unsigned r;
      logic [1:0] op;
      logic [23:0] addr;
      int hf, hl;
      bit cor;
      tests_run    = 0;
      tests_failed = 0;
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_addr   = '0;
      req_wdata  = '0;
      hold_req   = 1'b0;
      corrupt_en = 1'b0;
      for (int i = 0; i < 256; i++) begin
         r = $urandom_range(0, 255);
         flash_mem[i] = 8'(r);
         ref_mem[i]   = 8'(r);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // write 5A then read it back
      do_req(OP_WRITE, 24'h10, 8'h5A, 0, 0, 1'b0, 0, lat, err, rd);
      check("wr_lat", 32'(lat), VERIFY ? 32'd5 : 32'd3);
      check("wr_err", 32'(err), 32'(0));
      do_req(OP_READ, 24'h10, 8'h00, 0, 0, 1'b0, 0, lat, err, rd);
      check("rd_lat", 32'(lat), 32'd4);
      check("rd_err", 32'(err), 32'(0));
      check("rd_data", 32'(rd), 32'h5A);

      // erase then read the erased value
      do_req(OP_ERASE, 24'h10, 8'h00, 0, 0, 1'b0, 0, lat, err, rd);
      check("er_lat", 32'(lat), 32'd11);
      check("er_err", 32'(err), 32'(0));
      do_req(OP_READ, 24'h10, 8'h00, 0, 0, 1'b0, 0, lat, err, rd);
      check("rd_erased", 32'(rd), 32'hFF);

      // rejected requests
      do_req(OP_READ, 24'h000100, 8'h00, 0, 0, 1'b0, 0, lat, err, rd);
      check("oob_lat", 32'(lat), 32'd1);
      check("oob_err", 32'(err), 32'(1));
      check("oob_data", 32'(rd), 32'hFF);
      do_req(OP_ILLEGAL, 24'h20, 8'h00, 0, 0, 1'b0, 0, lat, err, rd);
      check("ill_lat", 32'(lat), 32'd1);
      check("ill_err", 32'(err), 32'(1));

      // hold for 5 cycles in SETUP of a read
      do_req(OP_WRITE, 24'h20, 8'h3C, 0, 0, 1'b0, 0, lat, err, rd);
      do_req(OP_READ, 24'h20, 8'h00, 1, 5, 1'b0, 0, lat, err, rd);
      check("hold_lat", 32'(lat), 32'd10);
      check("hold_data", 32'(rd), 32'h3C);

`ifdef OSPI_CTRL_WRITE_VERIFY_EN
      // read-back corrupted during compare
      do_req(OP_WRITE, 24'h30, 8'h5A, 0, 0, 1'b1, 0, lat, err, rd);
      check("vfy_lat", 32'(lat), 32'd5);
      check("vfy_err", 32'(err), 32'(1));
      check("vfy_data", 32'(rd), 32'h00);
`endif

      // reset during the erase busy wait
      do_req(OP_ERASE, 24'h40, 8'h00, 0, 0, 1'b0, 5, lat, err, rd);
      #1;
      check("abort_cs_n", 32'(flash_cs_n), 32'(1));
      check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("release_ready0", 32'(req_ready), 32'(0));
      @(negedge clk);
      #1;
      check("release_ready1", 32'(req_ready), 32'(1));

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 3) ? OP_READ : (r < 6) ? OP_WRITE : (r < 8) ? OP_ERASE :
              (r == 8) ? OP_ILLEGAL : OP_READ;
         r = $urandom_range(0, 9);
         addr = (r == 0) ? 24'($urandom) : (r < 6) ? 24'($urandom_range(0, 15)) :
                24'($urandom_range(0, 255));
         hf  = int'($urandom_range(1, 4));
         hl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         cor = VERIFY && ($urandom_range(0, 3) == 0);
         do_req(op, addr, 8'($urandom_range(0, 255)), hf, hl, cor, 0, lat, err, rd);
      end

      @(negedge clk);
      hold_req   = 1'b0;
      corrupt_en = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ospi_flash_ctrl.md
OSPI_FLASH_CTRL -- requirements
Module: ospi_flash_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 256, meaning the number of valid flash byte addresses (0..ADDR_LIMIT-1).
REQ-002 The block SHALL have parameter ERASE_CYCLES, default 8, meaning the erase busy wait in clk cycles (>=1).
REQ-003 The block SHALL have port clk  in  1  system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid in 1 and req_ready out 1, forming the host request handshake.
REQ-006 The block SHALL have port req_op  in  2  request operation: 00 read, 01 write, 10 erase, 11 illegal.
REQ-007 The block SHALL have ports req_addr in 24 (byte address) and req_wdata in 8 (write data).
REQ-008 The block SHALL have ports rsp_valid out 1, rsp_rdata out 8 and rsp_err out 1, carrying the response.
REQ-009 The block SHALL have port hold_req  in  1  host hold request.
REQ-010 The block SHALL have flash-side ports flash_cs_n out 1, flash_we out 1, flash_re out 1, flash_ee out 1, flash_addr out 24, flash_din out 8, flash_dout in 8 and flash_hold_n out 1.

Function
REQ-011 The block SHALL implement FSM states IDLE, SETUP, EXEC, CAPT, BUSY, VRD, VCMP and RESP.
REQ-012 In IDLE, req_ready SHALL equal 1; in every other state it SHALL be 0; a request SHALL be accepted on the edge where req_valid and req_ready are both 1.
REQ-013 On accept, the block SHALL latch op, addr and wdata; an illegal op or req_addr>=ADDR_LIMIT SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=FF and no flash access.
REQ-014 Otherwise the FSM SHALL go IDLE->SETUP, with flash_cs_n=0 and flash_addr/flash_din driven from the latches from SETUP until RESP is left.
REQ-015 SETUP SHALL advance to EXEC only when hold_req was 0 in both the current and the previous cycle; otherwise it SHALL remain in SETUP (flash hold lag).
REQ-016 In EXEC, exactly one of flash_re/flash_we/flash_ee SHALL be 1 for exactly one cycle, per op.
REQ-017 For a read, EXEC SHALL go to CAPT, and CAPT SHALL register flash_dout into rsp_rdata and go to RESP.
REQ-018 For a write, EXEC SHALL go to RESP, or to VRD when verify is compiled in (REQ-027).
REQ-019 For an erase, EXEC SHALL go to BUSY; BUSY SHALL count ERASE_CYCLES cycles with a counter of width $clog2(ERASE_CYCLES+1), then go to RESP.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle, with no backpressure; rsp_err=0 on success; then the FSM SHALL return to IDLE, with flash_cs_n=1 in IDLE.
REQ-021 Accept-to-rsp_valid latency without hold SHALL be: read 4 cycles, write 3, erase 3+ERASE_CYCLES, rejected 1.
REQ-022 flash_hold_n SHALL equal the registered !hold_req; hold_req SHALL stall only SETUP, and hold arriving in EXEC/CAPT/BUSY SHALL NOT abort the operation.
REQ-023 A request presented during RESP SHALL NOT be accepted until IDLE (no back-to-back overlap).

Reset
REQ-024 While reset_n=0, outputs SHALL be: state IDLE, req_ready 0, rsp_valid 0, rsp_err 0, rsp_rdata FF, flash_cs_n 1, all strobes 0, flash_addr 0, flash_din 0, flash_hold_n 1, counters 0.
REQ-025 Reset asserted mid-operation SHALL abort it immediately with no response generated; req_ready SHALL be 1 on the first edge after deassertion.

Configuration
REQ-026 Macro OSPI_CTRL_WRITE_VERIFY_EN SHALL select the write read-back verify feature.
REQ-027 With the macro defined, a write SHALL continue EXEC->VRD (flash_re=1 one cycle) ->VCMP (compare flash_dout to latched wdata) ->RESP, with rsp_err=1 on mismatch, rsp_rdata=read-back value, and write latency 5.
REQ-028 Without the macro, the VRD/VCMP logic SHALL be absent and write behaviour SHALL be as REQ-018.

Structure
REQ-029 Package ospi_ctrl_pkg SHALL hold the op encodings (OP_READ, OP_WRITE, OP_ERASE), the FSM state enum and the erased value 8'hFF.
REQ-030 The erase wait counter SHALL be sub-module ospi_busy_timer (load, count, done); all other logic SHALL be a single FSM.

Verification
REQ-031 Write 0x5A to address 0x10, then read 0x10 -> both rsp_err=0, read rsp_rdata=5A, latencies 3 and 4 cycles.
REQ-032 Erase 0x10, then read -> erase rsp after 3+ERASE_CYCLES cycles; read rsp_rdata=FF.
REQ-033 Read 0x000100 (ADDR_LIMIT=256) and req_op=11 -> rsp_valid 1 cycle after accept, rsp_err=1, flash_cs_n never 0.
REQ-034 hold_req=1 for 5 cycles starting in SETUP of a read -> no strobe while held, EXEC 2 cycles after release, correct data returned.
REQ-035 Assert reset_n=0 during BUSY of an erase -> flash_cs_n=1 next cycle, no rsp_valid, req_ready=1 after release.
REQ-036 With OSPI_CTRL_WRITE_VERIFY_EN and flash_dout forced to 0x00 during VCMP on a 0x5A write -> rsp_err=1, rsp_rdata=00, latency 5.
